// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and limits for the multi-channel PWM generator
package pwm_pkg;

    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_align_e;
    typedef enum logic {CNT_UP, CNT_DOWN} pwm_dir_e;

    localparam int PWM_MAX_CH = 32;

endpackage

// File: rtl/pwm_channel_compare.sv
// rtl/pwm_channel_compare.sv - one PWM channel: shadowed duty/polarity/enable, compare, output flop
module pwm_channel_compare
    import pwm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load_strobe,
    input  logic [WIDTH-1:0] counter,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             invert_in,
    input  logic             ch_enable_in,
    output logic             pwm_out
);

    logic [WIDTH-1:0] duty_q, duty_d;
    logic             invert_q, invert_d;
    logic             ch_enable_q, ch_enable_d;
    logic             out_q, out_d;
    logic             act;

    always_comb begin
        duty_d      = duty_q;
        invert_d    = invert_q;
        ch_enable_d = ch_enable_q;
        if (load_strobe) begin
            duty_d      = duty_in;
            invert_d    = invert_in;
            ch_enable_d = ch_enable_in;
        end
        act = (counter < duty_q);
        // While idle the pad follows the live invert input so polarity changes show within one cycle.
        if (!run) begin
            out_d = invert_in;
        end else if (ch_enable_q) begin
            out_d = act ^ invert_q;
        end else begin
            out_d = invert_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            duty_q      <= '0;
            invert_q    <= 1'b0;
            ch_enable_q <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            duty_q      <= duty_d;
            invert_q    <= invert_d;
            ch_enable_q <= ch_enable_d;
            out_q       <= out_d;
        end
    end

    assign pwm_out = out_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - shared period counter with edge/center alignment driving NUM_CH compare channels
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    center_mode,
    input  logic [WIDTH-1:0]        period_ticks,
    input  logic [NUM_CH*WIDTH-1:0] duty_ticks,
    input  logic [NUM_CH-1:0]       invert,
    input  logic [NUM_CH-1:0]       ch_enable,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start
);

    if (NUM_CH < 1 || NUM_CH > PWM_MAX_CH) begin : g_bad_num_ch
        $error("pwm_multi_channel: NUM_CH out of range");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    pwm_dir_e         dir_q, dir_d;
    pwm_align_e       mode_q, mode_d;
    logic             ps_q, ps_d;
    logic [WIDTH-1:0] last_val;
    logic             at_top;
    logic             boundary;
    logic             load;

    always_comb begin
        // Last count is P-1 computed at WIDTH bits; P=0 folds onto P=1 so nothing needs WIDTH+1.
        last_val = (period_q == '0) ? '0 : period_q - WIDTH'(1);
        at_top   = (cnt_q == last_val);
        boundary = (mode_q == PWM_EDGE) ? at_top : (dir_q == CNT_DOWN && cnt_q == '0);
        load     = !enable || boundary;

        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        period_d = period_q;

        if (!enable || boundary) begin
            cnt_d = '0;
            dir_d = CNT_UP;
        end else if (mode_q == PWM_CENTER && dir_q == CNT_DOWN) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else if (mode_q == PWM_CENTER && at_top) begin
            dir_d = CNT_DOWN;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        if (load) begin
            mode_d   = center_mode ? PWM_CENTER : PWM_EDGE;
            period_d = period_ticks;
        end

        ps_d = enable && (cnt_q == '0) && (dir_q == CNT_UP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            dir_q    <= CNT_UP;
            mode_q   <= PWM_EDGE;
            period_q <= '0;
            ps_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            ps_q     <= ps_d;
        end
    end

    assign period_start = ps_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel_compare #(.WIDTH(WIDTH)) u_ch (
            .clk          (clk),
            .rst          (rst),
            .run          (enable),
            .load_strobe  (load),
            .counter      (cnt_q),
            .duty_in      (duty_ticks[g*WIDTH +: WIDTH]),
            .invert_in    (invert[g]),
            .ch_enable_in (ch_enable[g]),
            .pwm_out      (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - scoreboard bench for pwm_multi_channel against a phase-index reference model
module tb_pwm_multi_channel;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             center_mode;
    logic [W-1:0]     period_ticks;
    logic [NCH*W-1:0] duty_ticks;
    logic [NCH-1:0]   invert;
    logic [NCH-1:0]   ch_enable;
    logic [NCH-1:0]   pwm_out;
    logic             period_start;

    pwm_multi_channel #(.NUM_CH(NCH), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .center_mode  (center_mode),
        .period_ticks (period_ticks),
        .duty_ticks   (duty_ticks),
        .invert       (invert),
        .ch_enable    (ch_enable),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] pwm;
        logic           ps;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: position t within the current period plus the configuration active for it.
    int             m_t;
    logic           m_center;
    int             m_p;
    int             m_d[NCH];
    logic [NCH-1:0] m_inv;
    logic [NCH-1:0] m_chen;

    task automatic model_load();
        m_center = center_mode;
        m_p      = int'(period_ticks);
        for (int c = 0; c < NCH; c++) m_d[c] = int'(duty_ticks[c*W +: W]);
        m_inv  = invert;
        m_chen = ch_enable;
    endtask

    task automatic model_step();
        exp_t e;
        int   pe, cval, len;
        pe   = (m_p == 0) ? 1 : m_p;
        len  = m_center ? 2 * pe : pe;
        cval = (!m_center || m_t < pe) ? m_t : 2 * pe - 1 - m_t;
        if (!rst) begin
            e = '0;
        end else if (!enable) begin
            e.pwm = invert;
            e.ps  = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++)
                e.pwm[c] = m_chen[c] ? ((cval < m_d[c]) ^ m_inv[c]) : m_inv[c];
            e.ps = (m_t == 0);
        end
        exp_q.push_back(e);

        if (!rst) begin
            m_t = 0; m_center = 1'b0; m_p = 0; m_inv = '0; m_chen = '0;
            for (int c = 0; c < NCH; c++) m_d[c] = 0;
        end else if (!enable || m_t == len - 1) begin
            model_load();
            m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    // Inputs are stable from one falling edge to the next; the model predicts the upcoming rising edge.
    task automatic step(int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic set_duty(int ch, int val);
        duty_ticks[ch*W +: W] = W'(val);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pwm_out !== e.pwm) begin
                failures++;
                $display("FAIL pwm_out t=%0t actual=%b expected=%b", $time, pwm_out, e.pwm);
            end
            checks++;
            if (period_start !== e.ps) begin
                failures++;
                $display("FAIL period_start t=%0t actual=%b expected=%b", $time, period_start, e.ps);
            end
        end
    end

    initial begin
        m_t = 0; m_center = 1'b0; m_p = 0; m_inv = '0; m_chen = '0;
        for (int c = 0; c < NCH; c++) m_d[c] = 0;
        rst = 1'b0; enable = 1'b0; center_mode = 1'b0;
        period_ticks = '0; duty_ticks = '0; invert = '0; ch_enable = '0;
        step(2);

        // Edge mode, duties below/at/above the period
        rst = 1'b1; period_ticks = 8'd4; ch_enable = '1;
        set_duty(0, 2); set_duty(1, 0); set_duty(2, 4); set_duty(3, 7);
        step(1);
        enable = 1'b1;
        step(12);

        // Center mode switch waits for the boundary
        center_mode = 1'b1;
        step(20);

        // Mid-period shadow update
        enable = 1'b0; center_mode = 1'b0; period_ticks = 8'd8; set_duty(0, 2);
        step(1);
        enable = 1'b1;
        step(4);
        set_duty(0, 6); period_ticks = 8'd5;
        step(15);

        // Disabled inverted channel, then enabled at next boundary
        invert = 4'b0010; ch_enable = 4'b1101;
        step(10);
        ch_enable = 4'b1111; set_duty(1, 1); period_ticks = 8'd4;
        step(12);

        // Degenerate periods
        invert = '0;
        for (int c = 0; c < NCH; c++) set_duty(c, 1);
        period_ticks = 8'd0;
        step(6);
        period_ticks = 8'd1;
        step(6);
        center_mode = 1'b1;
        step(6);
        center_mode = 1'b0;

        // Reset mid-period, disable, re-enable
        period_ticks = 8'd6; set_duty(0, 3);
        step(9);
        rst = 1'b0; step(1); rst = 1'b1;
        step(4);
        enable = 1'b0; invert = 4'b1010;
        step(2);
        enable = 1'b1;
        step(8);

        // Maximum period
        enable = 1'b0; invert = '0; period_ticks = 8'd255;
        set_duty(0, 255); set_duty(1, 0); set_duty(2, 128); set_duty(3, 254);
        step(1);
        enable = 1'b1;
        step(520);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) rst = 1'b0;
            else rst = 1'b1;
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            case ($urandom_range(0, 15))
                0: center_mode = $urandom_range(0, 1);
                1: period_ticks = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 255))
                                                               : W'($urandom_range(0, 9));
                2: set_duty($urandom_range(0, NCH - 1), $urandom_range(0, 12));
                3: invert = NCH'($urandom);
                4: ch_enable = NCH'($urandom);
                5: set_duty($urandom_range(0, NCH - 1), 255);
                default: ;
            endcase
            step(1);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
